bpsk_tx: RTL and testbench

Transmit-side counterpart of the Costas-loop receiver. It accepts a serial bit stream over a valid/ready handshake and maps each bit to ±1 (BPSK). It multiplies that symbol by an internally generated NCO cosine carrier and emits signed 8-bit samples, one per clock, ready to drive the receiver's 8-bit `din`. A fixed carrier-only preamble precedes data so the receiver loop can lock.

---
 rtl/bpsk_tx.sv | 202 ++++++++++++++++++++
 tb/tb_bpsk_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx.sv
// rtl/bpsk_tx.sv - BPSK modulator: bit handshake, carrier preamble, NCO cosine carrier, signed 8-bit samples
//
// Purpose: maps each accepted bit to +/-1 and multiplies it by a 64-entry cosine
// carrier driven by a 32-bit phase accumulator. A fixed all-'1' preamble precedes data.
// Ports:
//   clk, rst (sync, active-low)      - clock and reset
//   tx_en                            - level; start/continue transmission
//   bit_in, bit_valid, bit_ready     - one-entry bit input handshake
//   dout, dout_valid, sym_strobe     - registered sample, valid, first-sample-of-symbol
//   underrun                         - a DATA symbol was filled with '1'
//   busy                             - state is not IDLE
module bpsk_tx #(
    parameter int          SAMPLES_PER_SYM = 16,
    parameter int          PREAMBLE_LEN    = 32,
    parameter logic [31:0] FREQ_WORD       = 32'h2000_0000,
    parameter logic [31:0] PHASE_INIT      = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic signed [7:0] dout,
    output logic              dout_valid,
    output logic              sym_strobe,
    output logic              underrun,
    output logic              busy
);

    localparam int CW = $clog2(SAMPLES_PER_SYM);
    localparam int PW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_SYM - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [31:0]        phase_q, phase_d;
    logic               cur_bit_q, cur_bit_d;
    logic               fill_q, fill_d;          // current DATA symbol is an underrun fill
    logic               hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic signed [7:0]  dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               sym_strobe_q, sym_strobe_d;
    logic               underrun_q, underrun_d;

    logic signed [7:0]  lut_val;
    logic signed [7:0]  samp;

    // First quarter of round(127*cos(2*pi*k/64)), k = 0..16.
    function automatic logic [6:0] quarter(input logic [4:0] r);
        logic [6:0] v;
        case (r)
            5'd0:  v = 7'd127;
            5'd1:  v = 7'd126;
            5'd2:  v = 7'd125;
            5'd3:  v = 7'd122;
            5'd4:  v = 7'd117;
            5'd5:  v = 7'd112;
            5'd6:  v = 7'd106;
            5'd7:  v = 7'd98;
            5'd8:  v = 7'd90;
            5'd9:  v = 7'd81;
            5'd10: v = 7'd71;
            5'd11: v = 7'd60;
            5'd12: v = 7'd49;
            5'd13: v = 7'd37;
            5'd14: v = 7'd25;
            5'd15: v = 7'd12;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    // Full cosine from quarter-wave symmetry; magnitudes never exceed 127.
    function automatic logic signed [7:0] carrier(input logic [5:0] idx);
        logic [4:0]        r_fwd;
        logic [4:0]        r_rev;
        logic signed [7:0] mag_fwd;
        logic signed [7:0] mag_rev;
        logic signed [7:0] res;
        r_fwd   = {1'b0, idx[3:0]};
        r_rev   = 5'd16 - r_fwd;
        mag_fwd = $signed({1'b0, quarter(r_fwd)});
        mag_rev = $signed({1'b0, quarter(r_rev)});
        case (idx[5:4])
            2'd0:    res = mag_fwd;
            2'd1:    res = -mag_rev;
            2'd2:    res = -mag_fwd;
            default: res = mag_rev;
        endcase
        return res;
    endfunction

    assign lut_val = carrier(phase_q[31:26]);
    assign samp    = cur_bit_q ? lut_val : -lut_val;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pre_d        = pre_q;
        phase_d      = phase_q;
        cur_bit_d    = cur_bit_q;
        fill_d       = fill_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        dout_d       = 8'sd0;
        dout_valid_d = 1'b0;
        sym_strobe_d = 1'b0;
        underrun_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                phase_d = PHASE_INIT;
                cnt_d   = '0;
                if (tx_en) begin
                    state_d   = S_PREAMBLE;
                    cur_bit_d = 1'b1;
                    fill_d    = 1'b0;
                    pre_d     = '0;
                end
            end
            S_PREAMBLE, S_DATA: begin
                dout_d       = samp;
                dout_valid_d = 1'b1;
                sym_strobe_d = (cnt_q == '0);
                underrun_d   = (state_q == S_DATA) && (cnt_q == '0) && fill_q;
                phase_d      = phase_q + FREQ_WORD;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!tx_en) begin
                        state_d = S_IDLE;
                        phase_d = PHASE_INIT;
                    end else if (state_q == S_PREAMBLE && pre_q != PRE_LAST) begin
                        pre_d = pre_q + 1'b1;
                    end else begin
                        state_d = S_DATA;
                        if (hold_full_q) begin
                            cur_bit_d   = hold_q;
                            hold_full_d = 1'b0;
                            fill_d      = 1'b0;
                        end else begin
                            cur_bit_d = 1'b1;
                            fill_d    = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Load only when empty; a drain only happens when full, so they never collide.
        if (bit_valid && !hold_full_q) begin
            hold_d      = bit_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pre_q        <= '0;
            phase_q      <= PHASE_INIT;
            cur_bit_q    <= 1'b1;
            fill_q       <= 1'b0;
            hold_q       <= 1'b0;
            hold_full_q  <= 1'b0;
            dout_q       <= 8'sd0;
            dout_valid_q <= 1'b0;
            sym_strobe_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pre_q        <= pre_d;
            phase_q      <= phase_d;
            cur_bit_q    <= cur_bit_d;
            fill_q       <= fill_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sym_strobe_q <= sym_strobe_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bit_ready  = !hold_full_q;
    assign busy       = (state_q != S_IDLE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sym_strobe = sym_strobe_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_bpsk_tx.sv
// tb/tb_bpsk_tx.sv - self-checking bench for bpsk_tx with a behavioural reference model
module tb_bpsk_tx;

    localparam int          SPS = 4;
    localparam int          PL  = 2;
    localparam logic [31:0] FW  = 32'h2000_0000;
    localparam logic [31:0] PI  = 32'h0000_0000;
    localparam logic [31:0] FW_WRAP  = 32'hFFFF_FFFF;
    localparam logic [31:0] FW_SWEEP = 32'h0400_0000;

    logic clk = 1'b0;
    logic rst, tx_en, bit_in, bit_valid;
    logic rst2, en2;
    logic bit_ready, dout_valid, sym_strobe, underrun, busy;
    logic signed [7:0] dout;
    logic w_ready, w_valid, w_strobe, w_und, w_busy;
    logic signed [7:0] w_dout;
    logic s_ready, s_valid, s_strobe, s_und, s_busy;
    logic signed [7:0] s_dout;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int cap[$];
    int und_cap[$];
    int str_cap[$];

    always #5 clk = ~clk;

    bpsk_tx #(.SAMPLES_PER_SYM(SPS), .PREAMBLE_LEN(PL), .FREQ_WORD(FW), .PHASE_INIT(PI)) u_dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .dout(dout), .dout_valid(dout_valid),
        .sym_strobe(sym_strobe), .underrun(underrun), .busy(busy));

    bpsk_tx #(.SAMPLES_PER_SYM(SPS), .PREAMBLE_LEN(PL), .FREQ_WORD(FW_WRAP), .PHASE_INIT(PI)) u_wrap (
        .clk(clk), .rst(rst2), .tx_en(en2), .bit_in(1'b0), .bit_valid(1'b0),
        .bit_ready(w_ready), .dout(w_dout), .dout_valid(w_valid),
        .sym_strobe(w_strobe), .underrun(w_und), .busy(w_busy));

    bpsk_tx #(.SAMPLES_PER_SYM(SPS), .PREAMBLE_LEN(PL), .FREQ_WORD(FW_SWEEP), .PHASE_INIT(PI)) u_sweep (
        .clk(clk), .rst(rst2), .tx_en(en2), .bit_in(1'b0), .bit_valid(1'b0),
        .bit_ready(s_ready), .dout(s_dout), .dout_valid(s_valid),
        .sym_strobe(s_strobe), .underrun(s_und), .busy(s_busy));

    function automatic int lut_ref(input int k);
        real x;
        x = 127.0 * $cos(2.0 * 3.14159265358979 * k / 64.0);
        return int'($floor(x + 0.5));
    endfunction

    function automatic int phase_idx(input longint unsigned n, input longint unsigned fw);
        longint unsigned p;
        p = (n * fw) & 64'hFFFF_FFFF;
        return int'(p >> 26);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int capv(input int i);
        return (i < cap.size()) ? cap[i] : -999;
    endfunction
    function automatic int undv(input int i);
        return (i < und_cap.size()) ? und_cap[i] : -1;
    endfunction
    function automatic int strv(input int i);
        return (i < str_cap.size()) ? str_cap[i] : -1;
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Reference model: mode 0 idle, 1 preamble, 2 data.
    int          m_mode = 0, m_cnt = 0, m_sym = 0;
    logic [31:0] m_phase = PI;
    int          m_bit = 1, m_fill = 0, m_hold = 0, m_hold_full = 0;
    int          m_dout = 0, m_valid = 0, m_strobe = 0, m_und = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_mode = 0; m_cnt = 0; m_sym = 0; m_phase = PI; m_bit = 1; m_fill = 0;
                m_hold_full = 0; m_dout = 0; m_valid = 0; m_strobe = 0; m_und = 0;
            end else begin
                int take;
                take = (bit_valid && m_hold_full == 0) ? 1 : 0;
                if (m_mode != 0) begin
                    m_dout   = (m_bit != 0) ? lut_ref(int'(m_phase >> 26)) : -lut_ref(int'(m_phase >> 26));
                    m_valid  = 1;
                    m_strobe = (m_cnt == 0) ? 1 : 0;
                    m_und    = (m_mode == 2 && m_cnt == 0 && m_fill != 0) ? 1 : 0;
                    m_phase  = m_phase + FW;
                    if (m_cnt == SPS - 1) begin
                        m_cnt = 0;
                        if (!tx_en) begin
                            m_mode = 0;
                        end else if (m_mode == 1 && m_sym < PL - 1) begin
                            m_sym++;
                        end else begin
                            m_mode = 2;
                            if (m_hold_full != 0) begin
                                m_bit = m_hold; m_hold_full = 0; m_fill = 0;
                            end else begin
                                m_bit = 1; m_fill = 1;
                            end
                        end
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_dout = 0; m_valid = 0; m_strobe = 0; m_und = 0;
                    m_phase = PI; m_cnt = 0;
                    if (tx_en) begin
                        m_mode = 1; m_bit = 1; m_fill = 0; m_sym = 0;
                    end
                end
                if (take != 0) begin
                    m_hold = int'(bit_in); m_hold_full = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus sample capture for literal checks.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dout", int'(dout), m_dout);
            check("dout_valid", int'(dout_valid), m_valid);
            check("sym_strobe", int'(sym_strobe), m_strobe);
            check("underrun", int'(underrun), m_und);
            check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
            check("bit_ready", int'(bit_ready), (m_hold_full == 0) ? 1 : 0);
        end
        if (dout_valid) begin
            cap.push_back(int'(dout));
            und_cap.push_back(int'(underrun));
            str_cap.push_back(int'(sym_strobe));
        end
    end

    // Carrier-only instances: sample n carries phase n*FREQ_WORD, always positive sign.
    longint unsigned wn = 0, sn = 0;
    always @(negedge clk) begin
        if (rst2 && en2) begin
            if (w_valid) begin
                check("wrap_dout", int'(w_dout), lut_ref(phase_idx(wn, longint'(FW_WRAP))));
                check("wrap_not_m128", (w_dout == -8'sd128) ? 1 : 0, 0);
                wn++;
            end
            if (s_valid) begin
                check("sweep_dout", int'(s_dout), lut_ref(phase_idx(sn, longint'(FW_SWEEP))));
                sn++;
            end
        end
    end

    task automatic send_bit(input logic b);
        int t;
        bit_in = b;
        bit_valid = 1'b1;
        t = 0;
        while (!bit_ready && t < 200) begin
            tick;
            t++;
        end
        n_checks++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL send_timeout: actual %0d cycles required <200", t);
        end
        tick;
        bit_valid = 1'b0;
    endtask

    int exp1[12] = '{127, 90, 0, -90, -127, -90, 0, 90, 127, 90, 0, -90};
    int exp2[4]  = '{-127, -90, 0, 90};

    initial begin
        int base, t, n;
        rst = 1'b0; tx_en = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        rst2 = 1'b0; en2 = 1'b0;
        repeat (3) tick;
        chk_en = 1'b1;
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_strobe", int'(sym_strobe), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(bit_ready), 1);
        rst = 1'b1; rst2 = 1'b1; en2 = 1'b1;
        tick;

        // Free-running carrier, no bits offered.
        base = cap.size();
        tx_en = 1'b1;
        tick;
        check("start_valid_t1", int'(dout_valid), 0);
        tick;
        check("start_dout_t2", int'(dout), 127);
        check("start_strobe_t2", int'(sym_strobe), 1);
        repeat (20) tick;
        for (int i = 0; i < 12; i++) check($sformatf("carrier[%0d]", i), capv(base + i), exp1[i]);
        check("strobe_s0", strv(base + 0), 1);
        check("strobe_s1", strv(base + 1), 0);
        check("strobe_s4", strv(base + 4), 1);
        check("und_s4", undv(base + 4), 0);
        check("und_s8", undv(base + 8), 1);
        check("und_s9", undv(base + 9), 0);
        check("und_s12", undv(base + 12), 1);
        tx_en = 1'b0;
        t = 0;
        while (busy && t < 50) begin tick; t++; end
        check("stop1_busy", int'(busy), 0);

        // Bits 0,1,0 via handshake, first one preloaded while idle.
        bit_in = 1'b0; bit_valid = 1'b1;
        tick;
        bit_valid = 1'b0;
        check("preload_ready", int'(bit_ready), 0);
        base = cap.size();
        tx_en = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        t = 0;
        while (cap.size() <= base + 20 && t < 100) begin tick; t++; end
        for (int i = 0; i < 12; i++) check($sformatf("data[%0d]", i), capv(base + 8 + i), exp2[i % 4]);
        for (int s = 0; s < 3; s++) check($sformatf("data_und[%0d]", s), undv(base + 8 + 4 * s), 0);
        check("data_und_after", undv(base + 20), 1);

        // Drop tx_en at cnt=1 of a DATA symbol.
        t = 0;
        while (!sym_strobe && t < 20) begin tick; t++; end
        check("find_strobe", int'(sym_strobe), 1);
        tx_en = 1'b0;
        n = 0;
        repeat (6) begin
            tick;
            if (dout_valid) n++;
        end
        check("stop_samples", n, 3);
        check("stop_dout", int'(dout), 0);
        check("stop_busy", int'(busy), 0);
        tx_en = 1'b1;
        tick;
        tick;
        check("restart_dout", int'(dout), 127);
        check("restart_strobe", int'(sym_strobe), 1);

        // Reset mid-DATA with a held bit.
        repeat (10) tick;
        bit_in = 1'b0; bit_valid = 1'b1;
        tick;
        bit_valid = 1'b0;
        check("held_before_rst", int'(bit_ready), 0);
        rst = 1'b0;
        tick;
        check("midrst_dout", int'(dout), 0);
        check("midrst_valid", int'(dout_valid), 0);
        check("midrst_underrun", int'(underrun), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(bit_ready), 1);
        rst = 1'b1;
        base = cap.size();
        repeat (16) tick;
        for (int i = 0; i < 4; i++) check($sformatf("post_rst[%0d]", i), capv(base + 8 + i), exp1[i]);
        check("post_rst_und", undv(base + 8), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tick;
            if ($urandom_range(0, 99) < 3) tx_en = ~tx_en;
            bit_valid = ($urandom_range(0, 3) == 0);
            bit_in = $urandom_range(0, 1) != 0;
            rst = ($urandom_range(0, 249) != 0);
        end
        rst = 1'b1;
        bit_valid = 1'b0;
        tick;
        chk_en = 1'b0;
        check("wrap_samples_seen", (wn > 64) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
